// File: rtl/adder_pkg.sv
// Shared definitions for the adder result queue: adder width, result record, default depth.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_pkg;

  localparam int ADDER_W       = 4;
  localparam int REC_W         = ADDER_W + 2;
  localparam int DEFAULT_DEPTH = 4;

  // One stored adder result; packed so REC_W matches $bits(result_t).
  typedef struct packed {
    logic [ADDER_W-1:0] sum;
    logic               carryout;
    logic               overflow;
  } result_t;

endpackage

// File: rtl/adder_result_queue_sat_counter.sv
// Saturating up-counter with synchronous clear; clear coincident with inc yields 1.
// Latency: value updates on the edge after inc/clr.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, reset (sync, active-high), inc, clr, value[WIDTH-1:0].
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (clr) begin
      // The event arriving in the clearing cycle is counted, not lost.
      value <= inc ? WIDTH'(1) : '0;
    end else if (inc && (value != MAX_VAL)) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/adder_result_queue.sv
// Register-array FIFO of adder results {sum, carryout, overflow} plus saturating overflow count.
// Latency: one cycle from push edge to out_valid; no bypass path.
// Backpressure: in_ready = count < DEPTH (independent of out_ready); producer holds data when low.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_sum/in_carryout/in_overflow;
//        out_valid/out_ready/out_sum/out_carryout/out_overflow; count; ovf_count; ovf_clear.
// DEPTH must be a power of two in 2..16 so the pointers wrap by natural overflow.
module adder_result_queue
  import adder_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int OVF_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDER_W-1:0]       in_sum,
  input  logic                     in_carryout,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDER_W-1:0]       out_sum,
  output logic                     out_carryout,
  output logic                     out_overflow,
  output logic [$clog2(DEPTH):0]   count,
  output logic [OVF_CNT_W-1:0]     ovf_count,
  input  logic                     ovf_clear
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  result_t          mem [DEPTH];
  result_t          in_rec;
  result_t          head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;
  logic             push;
  logic             pop;

  // Both handshakes are functions of registered occupancy only.
  assign in_ready  = (occ < CNT_W'(DEPTH));
  assign out_valid = (occ != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = occ;

  assign in_rec = '{sum: in_sum, carryout: in_carryout, overflow: in_overflow};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage is not reset: stale entries are never visible because outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= in_rec;
    end
  end

  assign head         = mem[rd_ptr];
  assign out_sum      = out_valid ? head.sum      : '0;
  assign out_carryout = out_valid ? head.carryout : 1'b0;
  assign out_overflow = out_valid ? head.overflow : 1'b0;

  sat_counter #(
    .WIDTH (OVF_CNT_W)
  ) u_ovf_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (push & in_overflow),
    .clr   (ovf_clear),
    .value (ovf_count)
  );

endmodule

// File: tb/tb_adder_result_queue.sv
module tb_adder_result_queue;
  import adder_pkg::*;

  localparam int DEPTH     = 4;
  localparam int OVF_CNT_W = 8;
  localparam int OVF_MAX   = (1 << OVF_CNT_W) - 1;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [ADDER_W-1:0]     in_sum;
  logic                   in_carryout;
  logic                   in_overflow;
  logic                   out_valid;
  logic                   out_ready;
  logic [ADDER_W-1:0]     out_sum;
  logic                   out_carryout;
  logic                   out_overflow;
  logic [$clog2(DEPTH):0] count;
  logic [OVF_CNT_W-1:0]   ovf_count;
  logic                   ovf_clear;

  adder_result_queue #(
    .DEPTH     (DEPTH),
    .OVF_CNT_W (OVF_CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_carryout  (in_carryout),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_carryout (out_carryout),
    .out_overflow (out_overflow),
    .count        (count),
    .ovf_count    (ovf_count),
    .ovf_clear    (ovf_clear)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  // Reference model: a plain queue of records and an integer overflow tally.
  result_t mq[$];
  int      ovf_m = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       co;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural 4-bit signed adder producing the record the queue stores.
  function automatic result_t add4(input logic [3:0] a, input logic [3:0] b);
    result_t    r;
    logic [4:0] full;
    full       = {1'b0, a} + {1'b0, b};
    r.sum      = full[3:0];
    r.carryout = full[4];
    r.overflow = (a[3] == b[3]) && (full[3] != a[3]);
    return r;
  endfunction

  task automatic drive(input result_t r);
    in_sum      = r.sum;
    in_carryout = r.carryout;
    in_overflow = r.overflow;
  endtask

  task automatic check_model(input string tag);
    int      sz;
    result_t h;
    sz = mq.size();
    h  = (sz > 0) ? mq[0] : '0;
    chk({tag, ".count"},     int'(count),        sz);
    chk({tag, ".in_ready"},  int'(in_ready),     int'(sz < DEPTH));
    chk({tag, ".out_valid"}, int'(out_valid),    int'(sz > 0));
    chk({tag, ".out_sum"},   int'(out_sum),      int'(h.sum));
    chk({tag, ".out_co"},    int'(out_carryout), int'(h.carryout));
    chk({tag, ".out_ovf"},   int'(out_overflow), int'(h.overflow));
    chk({tag, ".ovf_count"}, int'(ovf_count),    ovf_m);
  endtask

  // Compare against the model, advance one clock, update the model with what the edge should do.
  task automatic tick(input string tag);
    bit      push_m;
    bit      pop_m;
    result_t rec;
    if (started) check_model(tag);
    push_m = !reset && in_valid && (mq.size() < DEPTH);
    pop_m  = !reset && out_ready && (mq.size() > 0);
    rec    = '{sum: in_sum, carryout: in_carryout, overflow: in_overflow};
    @(posedge clk);
    if (reset) begin
      mq.delete();
      ovf_m = 0;
    end else begin
      if (pop_m)  void'(mq.pop_front());
      if (push_m) mq.push_back(rec);
      if (ovf_clear)                                     ovf_m = (push_m && in_overflow) ? 1 : 0;
      else if (push_m && in_overflow && ovf_m < OVF_MAX) ovf_m++;
    end
    #1;
  endtask

  initial begin
    result_t exp_q[4];
    result_t r;

    vecs[0] = '{a: 4'd5,  b: 4'd3,  sum: 4'b1000, co: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 4'h8,  b: 4'hA,  sum: 4'b0010, co: 1'b1, ovf: 1'b1};
    vecs[2] = '{a: 4'hC,  b: 4'hD,  sum: 4'b1001, co: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 4'd2,  b: 4'd3,  sum: 4'b0101, co: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 4'hF,  b: 4'd1,  sum: 4'b0000, co: 1'b1, ovf: 1'b0};
    vecs[5] = '{a: 4'd7,  b: 4'd7,  sum: 4'b1110, co: 1'b0, ovf: 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ovf_clear = 1'b0;
    in_sum = '0; in_carryout = 1'b0; in_overflow = 1'b0;
    tick("rst");
    tick("rst");
    reset   = 1'b0;
    started = 1'b1;
    chk("reset.count",     int'(count),     0);
    chk("reset.out_valid", int'(out_valid), 0);
    chk("reset.in_ready",  int'(in_ready),  1);
    chk("reset.ovf_count", int'(ovf_count), 0);
    chk("reset.out_sum",   int'(out_sum),   0);

    // Table: push one adder result, see it one cycle later with exact fields, then empty outputs.
    for (int i = 0; i < 6; i++) begin
      drive(add4(vecs[i].a, vecs[i].b));
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick($sformatf("vec%0d.push", i));
      in_valid = 1'b0;
      chk($sformatf("vec%0d.valid", i), int'(out_valid),    1);
      chk($sformatf("vec%0d.sum", i),   int'(out_sum),      int'(vecs[i].sum));
      chk($sformatf("vec%0d.co", i),    int'(out_carryout), int'(vecs[i].co));
      chk($sformatf("vec%0d.ovf", i),   int'(out_overflow), int'(vecs[i].ovf));
      tick($sformatf("vec%0d.pop", i));
      chk($sformatf("vec%0d.empty", i), int'(out_valid), 0);
      chk($sformatf("vec%0d.zero", i),  int'(out_sum),   0);
    end
    chk("vec.ovf_count", int'(ovf_count), 3);

    // Fill with consumer stalled; fifth result must be held off.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r = add4(4'(i), 4'(i + 1));
      if (i < 4) exp_q[i] = r;
      drive(r);
      in_valid = 1'b1;
      chk($sformatf("fill%0d.in_ready", i), int'(in_ready), int'(i < 4));
      tick($sformatf("fill%0d", i));
    end
    in_valid = 1'b0;
    chk("full.count", int'(count), 4);
    chk("full.in_ready", int'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk($sformatf("stall%0d.hold", i), int'(out_sum), int'(exp_q[0].sum));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d.sum", i), int'(out_sum), int'(exp_q[i].sum));
      tick($sformatf("drain%0d", i));
    end
    chk("drain.count", int'(count), 0);

    // Steady state at count=2 with simultaneous push/pop; pointers wrap several times.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(add4(4'(i), 4'd9));
      tick("pre2");
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(add4(4'(i + 3), 4'(i * 5)));
      tick($sformatf("pp%0d", i));
      chk($sformatf("pp%0d.count", i), int'(count), 2);
    end
    in_valid = 1'b0;
    tick("pp.drain");
    tick("pp.drain");

    // Two negative additions queued back to back, popped in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(add4(4'h8, 4'hA)); tick("neg.push0");
    drive(add4(4'hC, 4'hD)); tick("neg.push1");
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("neg0.sum", int'(out_sum), 4'b0010);
    chk("neg0.co",  int'(out_carryout), 1);
    chk("neg0.ovf", int'(out_overflow), 1);
    tick("neg.pop0");
    chk("neg1.sum", int'(out_sum), 4'b1001);
    chk("neg1.co",  int'(out_carryout), 1);
    chk("neg1.ovf", int'(out_overflow), 0);
    tick("neg.pop1");
    chk("neg.empty_sum", int'(out_sum), 0);

    // Saturation: 300 overflowing pushes while draining.
    ovf_clear = 1'b1;
    tick("clr");
    ovf_clear = 1'b0;
    in_valid  = 1'b1;
    drive(add4(4'd5, 4'd3));
    for (int i = 0; i < 300; i++) tick("sat");
    chk("sat.ovf_count", int'(ovf_count), 255);
    ovf_clear = 1'b1;
    tick("clr_push");
    ovf_clear = 1'b0;
    in_valid  = 1'b0;
    chk("clr_push.ovf_count", int'(ovf_count), 1);
    tick("sat.drain");

    // Reset mid-operation with coincident handshakes.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(add4(4'(i), 4'd8));
      tick("pre_rst");
    end
    chk("pre_rst.count", int'(count), 3);
    reset     = 1'b1;
    out_ready = 1'b1;
    tick("mid_rst");
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst.count",     int'(count),     0);
    chk("mid_rst.out_valid", int'(out_valid), 0);
    chk("mid_rst.ovf_count", int'(ovf_count), 0);
    chk("mid_rst.in_ready",  int'(in_ready),  1);

    // Randomized traffic; bias alternates so the queue visits both full and empty.
    for (int i = 0; i < 2000; i++) begin
      bit fill_phase;
      fill_phase = ((i / 100) % 2) == 0;
      in_valid   = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      out_ready  = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(add4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))));
      ovf_clear  = ($urandom_range(0, 63) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      tick("rand");
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clear = 1'b0;
    tick("final");
    check_model("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
